piso_tx_scheduler: RTL

//   Round-robin scheduler for a parallel-in/serial-out shift register.

---
 rtl/piso_tx_scheduler.sv | 134 +++++++++++++
 1 files changed

// File: rtl/piso_tx_scheduler.sv
//------------------------------------------------------------------------------
// Module      : piso_tx_scheduler
// Description : Round-robin arbiter feeding an MSB-first serializer with frame
//               strobes, output stall and an idle gap between frames.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module piso_tx_scheduler #(
  parameter int DATA_W     = 8,
  parameter int NUM_REQ    = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]    req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic                         hold,
  output logic                         ser_out,
  output logic                         ser_valid,
  output logic                         frame_start,
  output logic                         frame_end,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output logic                         busy
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int BCW   = $clog2(DATA_W);
  localparam int GCW   = $clog2(GAP_CYCLES) + 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  logic [1:0]        state, state_nxt;
  logic [DATA_W-1:0] shreg;
  logic [BCW-1:0]    bit_cnt;
  logic [GCW-1:0]    gap_cnt;
  logic [IDX_W-1:0]  last;
  logic [IDX_W-1:0]  winner;
  logic              found;
  logic              last_bit;
  logic              gap_done;

  assign last_bit = (bit_cnt == BCW'(DATA_W - 1));
  assign gap_done = (gap_cnt == GCW'(GAP_CYCLES - 1));

  // Search starts just after the previous winner, wrapping modulo NUM_REQ.
  always_comb begin
    int               idx_int;
    logic [IDX_W-1:0] idx_sel;
    winner  = '0;
    found   = 1'b0;
    idx_int = 0;
    idx_sel = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx_int = (int'(last) + k) % NUM_REQ;
      idx_sel = IDX_W'(idx_int);
      if (!found && req_valid[idx_sel]) begin
        found  = 1'b1;
        winner = idx_sel;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (found)             state_nxt = ST_SHIFT;
      ST_SHIFT: if (!hold && last_bit) state_nxt = ST_GAP;
      ST_GAP:   if (gap_done)          state_nxt = ST_IDLE;
      default:                         state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready   = '0;
    ser_out     = 1'b0;
    ser_valid   = 1'b0;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    busy        = (state == ST_SHIFT) || (state == ST_GAP);
    // Gating with rst_n keeps the handshake quiet while reset is held.
    if (rst_n && state == ST_IDLE && found)
      req_ready = NUM_REQ'(1) << winner;
    if (state == ST_SHIFT) begin
      ser_out     = shreg[DATA_W-1];
      ser_valid   = !hold;
      frame_start = !hold && (bit_cnt == '0);
      frame_end   = !hold && last_bit;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg    <= '0;
      bit_cnt  <= '0;
      gap_cnt  <= '0;
      grant_id <= '0;
      last     <= IDX_W'(NUM_REQ - 1);
    end else begin
      case (state)
        ST_IDLE: begin
          if (found) begin
            shreg    <= req_data[winner*DATA_W +: DATA_W];
            grant_id <= winner;
            last     <= winner;
            bit_cnt  <= '0;
          end
        end
        ST_SHIFT: begin
          if (!hold) begin
            shreg <= {shreg[DATA_W-2:0], 1'b0};
            if (last_bit) gap_cnt <= '0;
            else          bit_cnt <= bit_cnt + 1'b1;
          end
        end
        ST_GAP: begin
          if (!gap_done) gap_cnt <= gap_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire
